decode_writeback: RTL and testbench

Register-file stage of the SEQ Y86-64 processor, directly downstream of fetch. It consumes the fetch fields (icode, rA, rB) and produces operands valA/valB for execute. At the end of each cycle it retires results valE/valM from execute/memory into fifteen 64-bit program registers. All register state lives here; decode is combinational from that state, and writeback is the block's only sequential update.

---
 rtl/decode_writeback_if.sv | 36 +++
 rtl/decode_writeback.sv | 125 ++++++++++++
 tb/tb_decode_writeback.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_writeback_if.sv
// ============================================================================
//  decode_writeback_if
//  Fetch/execute-facing signal bundle of the Y86-64 register-file stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [3:0]  dbg_sel;
  logic [63:0] dbg_val;

  modport master (
    output icode, rA, rB, Cnd, valE, valM, wb_en, dbg_sel,
    input  valA, valB, srcA, srcB, dstE, dstM, dbg_val
  );

  modport slave (
    input  icode, rA, rB, Cnd, valE, valM, wb_en, dbg_sel,
    output valA, valB, srcA, srcB, dstE, dstM, dbg_val
  );
endinterface

`default_nettype wire

// File: rtl/decode_writeback.sv
// ============================================================================
//  decode_writeback
//  SEQ Y86-64 decode (combinational operand read) and writeback register file.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  decode_writeback_if.slave   bus
);

  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] rf_q    [15];
  logic [63:0] rf_d    [15];
  logic [63:0] rd_view [16];

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (bus.icode)
      I_CMOVXX: begin
        src_a = bus.rA;
        dst_e = bus.Cnd ? bus.rB : R_NONE;
      end
      I_IRMOVQ: dst_e = bus.rB;
      I_RMMOVQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      I_MRMOVQ: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      I_OPQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      I_CALL: begin
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_RET: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_PUSHQ: begin
        src_a = bus.rA;
        src_b = R_RSP;
        dst_e = R_RSP;
      end
      I_POPQ: begin
        src_a = R_RSP;
        src_b = R_RSP;
        dst_e = R_RSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // Entry 15 models the null register so every 4-bit ID indexes safely.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rd_view[i] = rf_q[i];
    end
    rd_view[15] = '0;
  end

  assign bus.valA    = rd_view[src_a];
  assign bus.valB    = rd_view[src_b];
  assign bus.dbg_val = rd_view[bus.dbg_sel];
  assign bus.srcA    = src_a;
  assign bus.srcB    = src_b;
  assign bus.dstE    = dst_e;
  assign bus.dstM    = dst_m;

  // The dstM update is applied after dstE so valM wins on a shared target.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (bus.wb_en) begin
        if (dst_e == 4'(i)) rf_d[i] = bus.valE;
        if (dst_m == 4'(i)) rf_d[i] = bus.valM;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_writeback.sv
// ============================================================================
//  tb_decode_writeback
//  Randomised scoreboard bench for the Y86-64 decode/writeback register file.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decode_writeback;

  localparam logic [63:0] RSP_INIT = 64'h200;

  logic clk;
  logic rst;
  decode_writeback_if bus ();

  decode_writeback #(.RSP_INIT(RSP_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] dv;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  de;
    logic [3:0]  dm;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mdl [16];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference decode tables taken straight from the instruction definitions.
  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb,
                                         input logic cnd);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return cnd ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 16; i++) mdl[i] = (i == 4) ? RSP_INIT : 64'h0;
  endtask

  function automatic exp_t mk_exp(input logic [3:0] ic, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic cnd,
                                  input logic [3:0] ds, input string tag);
    exp_t e;
    e.sa  = m_src_a(ic, ra);
    e.sb  = m_src_b(ic, rb);
    e.de  = m_dst_e(ic, rb, cnd);
    e.dm  = m_dst_m(ic, ra);
    e.va  = mdl[e.sa];
    e.vb  = mdl[e.sb];
    e.dv  = mdl[ds];
    e.tag = tag;
    return e;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s %s: got %h expected %h", tag, nm, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs whenever an expectation is presented.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      chk(e.tag, "valA",    bus.valA,    e.va);
      chk(e.tag, "valB",    bus.valB,    e.vb);
      chk(e.tag, "dbg_val", bus.dbg_val, e.dv);
      chk(e.tag, "srcA",    64'(bus.srcA), 64'(e.sa));
      chk(e.tag, "srcB",    64'(bus.srcB), 64'(e.sb));
      chk(e.tag, "dstE",    64'(bus.dstE), 64'(e.de));
      chk(e.tag, "dstM",    64'(bus.dstM), 64'(e.dm));
    end
  end

  task automatic step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                      input logic cnd, input logic [63:0] ve, input logic [63:0] vm,
                      input logic we, input logic [3:0] ds, input string tag);
    exp_t e;
    @(negedge clk);
    bus.icode = ic; bus.rA = ra; bus.rB = rb; bus.Cnd = cnd;
    bus.valE = ve; bus.valM = vm; bus.wb_en = we; bus.dbg_sel = ds;
    #1;
    e = mk_exp(ic, ra, rb, cnd, ds, tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst && we) begin
      if (e.de != 4'hF) mdl[e.de] = ve;
      if (e.dm != 4'hF) mdl[e.dm] = vm;
    end
  endtask

  // Short reset pulse between edges; contents must revert before the next edge.
  task automatic pulse_rst(input logic [3:0] ds, input string tag);
    @(negedge clk);
    bus.icode = 4'h0; bus.wb_en = 1'b0; bus.dbg_sel = ds;
    #1;
    rst = 1'b1;
    reset_model();
    #1;
    exp_q.push_back(mk_exp(4'h0, 4'h0, 4'h0, 1'b0, ds, tag));
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.icode = 4'h0; bus.rA = 4'h0; bus.rB = 4'h0; bus.Cnd = 1'b0;
    bus.valE = '0; bus.valM = '0; bus.wb_en = 1'b0; bus.dbg_sel = 4'h0;
    reset_model();

    // Register sweep held in reset while attempting writes that must be dropped.
    for (int i = 0; i < 16; i++) begin
      step(4'h3, 4'hF, 4'(i), 1'b0, 64'hDEAD_0000 + 64'(i), 64'h0, 1'b1, 4'(i), "reset_sweep");
    end
    @(negedge clk);
    bus.wb_en = 1'b0;
    rst = 1'b0;

    step(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b1, 4'h2, "irmovq_pre");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'h2, "irmovq_post");
    step(4'h3, 4'hF, 4'h2, 1'b0, 64'h5,    64'h0, 1'b1, 4'h2, "ld_r2");
    step(4'h3, 4'hF, 4'h3, 1'b0, 64'h7,    64'h0, 1'b1, 4'h3, "ld_r3");
    step(4'h6, 4'h2, 4'h3, 1'b0, 64'hC,    64'h0, 1'b1, 4'h3, "opq");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'h3, "opq_post");
    step(4'h2, 4'h1, 4'h6, 1'b0, 64'hAA,   64'h0, 1'b1, 4'h6, "cmov_nt");
    step(4'h2, 4'h1, 4'h6, 1'b1, 64'hAA,   64'h0, 1'b1, 4'h6, "cmov_t");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'h6, "cmov_post");
    step(4'hB, 4'h4, 4'hF, 1'b0, 64'h208,  64'h55, 1'b1, 4'h4, "popq_rsp");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'h4, "popq_post");
    step(4'h3, 4'hF, 4'h1, 1'b0, 64'hFF,   64'h0, 1'b0, 4'h1, "wb_dis");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'h1, "wb_dis_post");
    step(4'hE, 4'h1, 4'h2, 1'b1, 64'h99,   64'h98, 1'b1, 4'h2, "invalid");
    pulse_rst(4'h4, "mid_rst_rsp");
    step(4'h6, 4'h3, 4'h2, 1'b0, 64'h0,    64'h0, 1'b0, 4'h3, "post_rst");
    step(4'hA, 4'h6, 4'hF, 1'b0, 64'h1F8,  64'h0, 1'b1, 4'h4, "pushq");
    step(4'h0, 4'h0, 4'h0, 1'b0, 64'h0,    64'h0, 1'b0, 4'hF, "dbg_null");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_rst(4'($urandom_range(0, 15)), "rand_rst");
      end else begin
        step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)), "random");
      end
    end

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
